// File: rtl/mesh_term_pkg.sv
// Shared field geometry, FSM states and destination matching for the mesh terminal sink.
package mesh_term_pkg;

  localparam int NXT_W  = 8;
  localparam int ROW_W  = 4;
  localparam int COL_W  = 4;
  localparam int DEST_W = ROW_W + COL_W;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    SETTLE
  } state_t;

  // Takes only the {row,col} header field so the helper stays independent of PAKG_SIZE.
  function automatic logic is_for_me(input logic [DEST_W-1:0] pkt_dest,
                                     input logic [ROW_W-1:0]  row,
                                     input logic [COL_W-1:0]  col,
                                     input logic [DEST_W-1:0] bdcst);
    return (pkt_dest == {row, col}) || (pkt_dest == bdcst);
  endfunction

endpackage

// File: rtl/term_fifo.sv
// Circular first-word-fall-through buffer with occupancy count; head reads as zero when empty.
module term_fifo
  import mesh_term_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;

  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign do_rd    = rd_en && rd_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i && wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({wr_en, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mesh_term_sink.sv
// Terminal endpoint draining one mesh exit FIFO: pops with a 3-cycle handshake,
// keeps packets addressed here (or broadcast), drops and counts misrouted ones.
module mesh_term_sink
  import mesh_term_pkg::*;
#(
  parameter int               PAKG_SIZE = 32,
  parameter int               BUF_DEPTH = 4,
  parameter logic [ROW_W-1:0] ROW_ID    = 4'd1,
  parameter logic [COL_W-1:0] COL_ID    = 4'd1,
  parameter logic [DEST_W-1:0] BDCST    = 8'hFF,
  parameter int               CNT_W     = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic                         pndng_i,
  input  logic [PAKG_SIZE-1:0]         data_out_i,
  output logic                         pop_o,
  output logic                         pkt_valid_o,
  output logic [PAKG_SIZE-1:0]         pkt_data_o,
  input  logic                         pkt_ready_i,
  output logic                         misroute_o,
  output logic [CNT_W-1:0]             rx_cnt_o,
  output logic [CNT_W-1:0]             err_cnt_o,
  output logic [$clog2(BUF_DEPTH):0]   buf_cnt_o
);

  localparam int BCW = $clog2(BUF_DEPTH) + 1;
  localparam logic [BCW-1:0]   FULL_CNT = BCW'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  logic [DEST_W-1:0] dest;
  logic              for_me;
  logic              wr_en;
  logic              has_room;

  assign dest     = data_out_i[PAKG_SIZE-NXT_W-1 -: DEST_W];
  assign for_me   = is_for_me(dest, ROW_ID, COL_ID, BDCST);
  assign wr_en    = (state == POP) && for_me;
  // The write lands on the POP edge, so by IDLE the count already includes it.
  assign has_room = (buf_cnt_o != FULL_CNT);

  term_fifo #(
    .WIDTH (PAKG_SIZE),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en    (wr_en),
    .wr_data  (data_out_i),
    .rd_en    (pkt_ready_i),
    .rd_valid (pkt_valid_o),
    .rd_data  (pkt_data_o),
    .count    (buf_cnt_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      pop_o      <= 1'b0;
      misroute_o <= 1'b0;
      rx_cnt_o   <= '0;
      err_cnt_o  <= '0;
    end else begin
      misroute_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i && pndng_i && has_room) begin
            state <= POP;
            pop_o <= 1'b1;
          end
        end
        POP: begin
          pop_o <= 1'b0;
          state <= SETTLE;
          if (for_me) begin
            if (rx_cnt_o != '1) rx_cnt_o <= rx_cnt_o + CNT_ONE;
          end else begin
            misroute_o <= 1'b1;
            if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_ONE;
          end
        end
        SETTLE: state <= IDLE;
        default: begin
          state <= IDLE;
          pop_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_term_sink.sv
// Scoreboard bench: a queue models the mesh exit FIFO, expected deliveries are queued at send time.
module tb_mesh_term_sink;

  localparam int PW    = 32;
  localparam int BD    = 4;
  localparam int CNT_W = 16;
  localparam int BCW   = $clog2(BD) + 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             enable_i = 1'b0;
  logic             pndng_i = 1'b0;
  logic [PW-1:0]    data_out_i = '0;
  logic             pkt_ready_i = 1'b0;
  logic             pop_o;
  logic             pkt_valid_o;
  logic [PW-1:0]    pkt_data_o;
  logic             misroute_o;
  logic [CNT_W-1:0] rx_cnt_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [BCW-1:0]   buf_cnt_o;

  mesh_term_sink #(
    .PAKG_SIZE (PW),
    .BUF_DEPTH (BD),
    .ROW_ID    (4'd1),
    .COL_ID    (4'd1),
    .BDCST     (8'hFF),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .pndng_i     (pndng_i),
    .data_out_i  (data_out_i),
    .pop_o       (pop_o),
    .pkt_valid_o (pkt_valid_o),
    .pkt_data_o  (pkt_data_o),
    .pkt_ready_i (pkt_ready_i),
    .misroute_o  (misroute_o),
    .rx_cnt_o    (rx_cnt_o),
    .err_cnt_o   (err_cnt_o),
    .buf_cnt_o   (buf_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] mesh_q[$];
  logic [PW-1:0] exp_q[$];
  int exp_rx = 0;
  int exp_err = 0;
  int mis_pulses = 0;
  int pop_cnt = 0;
  int cyc = 0;
  int last_pop = -100;
  int pop_times[$];
  bit rand_drive = 1'b0;
  bit prev_mis = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Reference rule: keep if {row,col} is 1,1 or broadcast, otherwise count as misroute.
  task automatic send(input logic [PW-1:0] p);
    logic [7:0] d;
    d = p[23:16];
    mesh_q.push_back(p);
    if (d == 8'h11 || d == 8'hFF) begin
      exp_q.push_back(p);
      exp_rx++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic wait_mesh(input int budget, input string name);
    int n;
    n = 0;
    while (mesh_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
    if (n >= budget) chk({name, "_timeout"}, mesh_q.size(), 0);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((mesh_q.size() != 0 || exp_q.size() != 0 || buf_cnt_o != 0) && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
    if (n >= budget) chk({name, "_timeout"}, exp_q.size() + mesh_q.size(), 0);
  endtask

  // Mesh exit FIFO: show-ahead head, advances the edge after a pop strobe.
  initial begin : mesh_model
    bit popped;
    forever begin
      @(negedge clk_i);
      popped = pop_o;
      if (pop_o) begin
        pop_cnt++;
        pop_times.push_back(cyc);
        checks++;
        if (cyc - last_pop < 3) begin
          errors++;
          $display("FAIL pop_spacing actual=%0d expected>=3", cyc - last_pop);
        end
        last_pop = cyc;
        chk("pop_nonempty", mesh_q.size() != 0, 1);
      end
      @(posedge clk_i);
      #1;
      if (popped && mesh_q.size() != 0) void'(mesh_q.pop_front());
      pndng_i = (mesh_q.size() != 0);
      data_out_i = (mesh_q.size() != 0) ? mesh_q[0] : '0;
    end
  end

  initial begin : monitor
    logic [PW-1:0] e;
    forever begin
      @(negedge clk_i);
      if (pkt_valid_o && pkt_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pkt actual=%0h expected=none", pkt_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("pkt_data", pkt_data_o, e);
        end
      end
      if (misroute_o) begin
        mis_pulses++;
        chk("misroute_width", prev_mis, 0);
      end
      prev_mis = misroute_o;
      if (buf_cnt_o > BD) chk("buf_overflow", buf_cnt_o, BD);
    end
  end

  initial begin : rand_driver
    forever begin
      @(posedge clk_i);
      #2;
      if (rand_drive) begin
        pkt_ready_i = ($urandom_range(0, 3) != 0);
        enable_i    = ($urandom_range(0, 4) != 0);
      end
    end
  end

  initial begin : main
    int p0;
    logic [7:0] d;
    logic [PW-1:0] pkt;
    int n;

    rst_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b1;
    enable_i = 1'b1;
    repeat (10) tick();
    chk("rst_pop", pop_o, 0);
    chk("rst_valid", pkt_valid_o, 0);
    chk("rst_data", pkt_data_o, 0);
    chk("rst_rx", rx_cnt_o, 0);
    chk("rst_err", err_cnt_o, 0);
    chk("rst_buf", buf_cnt_o, 0);
    chk("rst_popcnt", pop_cnt, 0);

    // Own address, consumer stalled so the head stays visible
    p0 = pop_cnt;
    send(32'h0011_8ABC);
    wait_mesh(50, "own");
    chk("own_pops", pop_cnt - p0, 1);
    chk("own_valid", pkt_valid_o, 1);
    chk("own_head", pkt_data_o, 32'h0011_8ABC);
    chk("own_rx", rx_cnt_o, 1);
    chk("own_buf", buf_cnt_o, 1);
    pkt_ready_i = 1'b1;
    wait_drain(50, "own_drain");
    chk("own_valid_fall", pkt_valid_o, 0);

    // Misrouted
    p0 = pop_cnt;
    send(32'h0023_0001);
    wait_mesh(50, "mis");
    chk("mis_pops", pop_cnt - p0, 1);
    chk("mis_err", err_cnt_o, 1);
    chk("mis_pulses", mis_pulses, 1);
    chk("mis_buf", buf_cnt_o, 0);

    // Broadcast
    send(32'h00FF_1234);
    wait_drain(50, "bc");
    chk("bc_rx", rx_cnt_o, 2);

    // Fill to capacity with consumer stalled
    pkt_ready_i = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 6; i++) send({8'h00, 8'h11, 16'(16'hA000 + i)});
    repeat (40) tick();
    chk("full_pops", pop_cnt - p0, 4);
    chk("full_buf", buf_cnt_o, 4);
    chk("full_left", mesh_q.size(), 2);
    chk("full_popo", pop_o, 0);
    pkt_ready_i = 1'b1;
    wait_drain(200, "full_drain");
    chk("full_total_pops", pop_cnt - p0, 6);
    chk("full_rx", rx_cnt_o, exp_rx);

    // Reset landing on the POP cycle
    send(32'h0011_0042);
    n = 0;
    while (!pop_o && n < 50) begin
      tick();
      n++;
    end
    chk("rstpop_seen", pop_o, 1);
    rst_i = 1'b0;
    tick();
    chk("rstpop_pop", pop_o, 0);
    chk("rstpop_valid", pkt_valid_o, 0);
    chk("rstpop_mis", misroute_o, 0);
    chk("rstpop_rx", rx_cnt_o, 0);
    chk("rstpop_err", err_cnt_o, 0);
    chk("rstpop_buf", buf_cnt_o, 0);
    exp_q.delete();
    exp_rx = 0;
    exp_err = 0;
    mis_pulses = 0;
    rst_i = 1'b1;
    tick();
    pop_times.delete();
    send(32'h0011_0001);
    send(32'h00FF_0002);
    wait_drain(100, "post_rst");
    chk("post_rst_pops", pop_times.size(), 2);
    if (pop_times.size() == 2) chk("post_rst_spacing", pop_times[1] - pop_times[0], 3);
    chk("post_rst_rx", rx_cnt_o, 2);

    // Randomized traffic with random enable, consumer stalls and gaps
    rand_drive = 1'b1;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: d = 8'h11;
        1: d = 8'hFF;
        default: d = 8'($urandom_range(0, 255));
      endcase
      pkt = $urandom;
      pkt[23:16] = d;
      send(pkt);
      repeat ($urandom_range(0, 4)) tick();
    end
    rand_drive = 1'b0;
    tick();
    pkt_ready_i = 1'b1;
    enable_i = 1'b1;
    wait_drain(3000, "rand_drain");
    chk("final_rx", rx_cnt_o, exp_rx);
    chk("final_err", err_cnt_o, exp_err);
    chk("final_mis_pulses", mis_pulses, exp_err);
    chk("final_exp_empty", exp_q.size(), 0);
    chk("final_buf", buf_cnt_o, 0);
    chk("final_valid", pkt_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
